// File: rtl/mant_norm_seq_pkg.sv
// rtl/mant_norm_seq_pkg.sv - widths, exponent limit and FSM states for the mantissa normalizer
package mant_norm_seq_pkg;

  localparam int MW = 25;
  localparam int EW = 8;
  localparam logic [EW-1:0] EXP_MAX = {EW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADD    = 3'd1,
    ST_NORM_R = 3'd2,
    ST_NORM_L = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mant_addsub.sv
// rtl/mant_addsub.sv - combinational mantissa add or magnitude subtract
module mant_addsub
  import mant_norm_seq_pkg::*;
(
  input  logic [MW-1:0] a_i,
  input  logic [MW-1:0] b_i,
  input  logic          op_sub_i,
  output logic [MW:0]   res_o,
  output logic          b_gt_a_o
);

  // Result carries one extra bit so an addition carry is visible to the normalizer.
  always_comb begin
    b_gt_a_o = op_sub_i && (b_i > a_i);
    if (!op_sub_i) begin
      res_o = {1'b0, a_i} + {1'b0, b_i};
    end else if (b_i > a_i) begin
      res_o = {1'b0, b_i - a_i};
    end else begin
      res_o = {1'b0, a_i - b_i};
    end
  end

endmodule

// File: rtl/mant_norm_seq.sv
// rtl/mant_norm_seq.sv - sequential add/sub with one-bit-per-cycle normalization
module mant_norm_seq
  import mant_norm_seq_pkg::*;
(
  input  logic            clk,
  input  logic            clear,
  input  logic            start,
  output logic            ready,
  input  logic [2*MW-1:0] saved_mants,
  input  logic            op_sub,
  input  logic [EW-1:0]   exp_in,
  output logic [MW-1:0]   mant_out,
  output logic [EW-1:0]   exp_out,
  output logic            sign_flip,
  output logic            zero,
  output logic            overflow,
  output logic            underflow,
  output logic            done
);

  state_t        state_q, state_d;
  logic [MW-1:0] a_q, a_d, b_q, b_d;
  logic          sub_q, sub_d;
  logic [EW-1:0] exp_in_q, exp_in_d;
  logic [MW:0]   acc_q, acc_d;
  logic [EW-1:0] exp_q, exp_d;
  logic          flip_q, flip_d;
  logic [MW-1:0] mant_q, mant_d;
  logic [EW-1:0] expo_q, expo_d;
  logic          zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [MW:0]   sum;
  logic          b_gt_a;
  logic [EW-1:0] exp_inc;
  logic [MW:0]   acc_shl;

  mant_addsub u_addsub (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_sub_i (sub_q),
    .res_o    (sum),
    .b_gt_a_o (b_gt_a)
  );

  // State register; clear drops back to idle and wipes every result.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Working and result registers.
  always_ff @(posedge clk) begin
    if (clear) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      exp_in_q <= '0;
      acc_q    <= '0;
      exp_q    <= '0;
      flip_q   <= 1'b0;
      mant_q   <= '0;
      expo_q   <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      exp_in_q <= exp_in_d;
      acc_q    <= acc_d;
      exp_q    <= exp_d;
      flip_q   <= flip_d;
      mant_q   <= mant_d;
      expo_q   <= expo_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Next-state and datapath: results are written on the edge that enters DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    exp_in_d = exp_in_q;
    acc_d    = acc_q;
    exp_d    = exp_q;
    flip_d   = flip_q;
    mant_d   = mant_q;
    expo_d   = expo_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    exp_inc  = (exp_q == EXP_MAX) ? EXP_MAX : exp_q + 1'b1;
    acc_shl  = {acc_q[MW-1:0], 1'b0};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = saved_mants[2*MW-1:MW];
          b_d      = saved_mants[MW-1:0];
          sub_d    = op_sub;
          exp_in_d = exp_in;
          flip_d   = 1'b0;
          mant_d   = '0;
          expo_d   = '0;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          state_d  = ST_ADD;
        end
      end
      ST_ADD: begin
        acc_d  = sum;
        exp_d  = exp_in_q;
        flip_d = b_gt_a;
        if (sum == '0) begin
          zero_d  = 1'b1;
          state_d = ST_DONE;
        end else if (sum[MW]) begin
          state_d = ST_NORM_R;
        end else if (sum[MW-1]) begin
          mant_d  = sum[MW-1:0];
          expo_d  = exp_in_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_NORM_L;
        end
      end
      ST_NORM_R: begin
        exp_d = exp_inc;
        if (exp_inc == EXP_MAX) begin
          ovf_d  = 1'b1;
          mant_d = '0;
        end else begin
          mant_d = acc_q[MW:1];
        end
        expo_d  = exp_inc;
        state_d = ST_DONE;
      end
      ST_NORM_L: begin
        // Each shift lands in DONE as soon as the hidden bit arrives, so k shifts cost k edges.
        // A nonzero accumulator reaches the hidden bit within MW-1 shifts.
        if (acc_q[MW-1]) begin
          mant_d  = acc_q[MW-1:0];
          expo_d  = exp_q;
          state_d = ST_DONE;
        end else if (exp_q > EW'(1)) begin
          acc_d = acc_shl;
          exp_d = exp_q - 1'b1;
          if (acc_shl[MW-1]) begin
            mant_d  = acc_shl[MW-1:0];
            expo_d  = exp_q - 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          unf_d   = 1'b1;
          mant_d  = acc_q[MW-1:0];
          expo_d  = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign mant_out  = mant_q;
  assign exp_out   = expo_q;
  assign sign_flip = flip_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_mant_norm_seq.sv
// tb/tb_mant_norm_seq.sv - randomized self-checking bench for mant_norm_seq
module tb_mant_norm_seq;
  import mant_norm_seq_pkg::*;

  logic            clk = 1'b0;
  logic            clear;
  logic            start;
  logic            ready;
  logic [2*MW-1:0] saved_mants;
  logic            op_sub;
  logic [EW-1:0]   exp_in;
  logic [MW-1:0]   mant_out;
  logic [EW-1:0]   exp_out;
  logic            sign_flip, zero, overflow, underflow, done;

  int n_vec = 0;
  int n_err = 0;

  mant_norm_seq dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .ready       (ready),
    .saved_mants (saved_mants),
    .op_sub      (op_sub),
    .exp_in      (exp_in),
    .mant_out    (mant_out),
    .exp_out     (exp_out),
    .sign_flip   (sign_flip),
    .zero        (zero),
    .overflow    (overflow),
    .underflow   (underflow),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mantissa value.
  task automatic model(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic sub,
                       input logic [EW-1:0] e, output logic [MW-1:0] m, output logic [EW-1:0] eo,
                       output logic fl, output logic z, output logic ov, output logic un,
                       output int lat);
    longint va, vb, s, hid, top;
    int     ex, shifts;
    va  = longint'(a);
    vb  = longint'(b);
    hid = longint'(1) << (MW-1);
    top = longint'(1) << MW;
    fl  = sub && (vb > va);
    s   = !sub ? va + vb : (fl ? vb - va : va - vb);
    z = 0; ov = 0; un = 0; m = '0; eo = '0;
    if (s == 0) begin
      z = 1; lat = 2;
    end else if (s >= top) begin
      ex  = (int'(e) >= int'(EXP_MAX)) ? int'(EXP_MAX) : int'(e) + 1;
      lat = 3;
      eo  = EW'(ex);
      if (ex == int'(EXP_MAX)) ov = 1;
      else m = MW'(s / 2);
    end else if (s >= hid) begin
      m = MW'(s); eo = e; lat = 2;
    end else begin
      ex = int'(e);
      shifts = 0;
      while (s < hid && ex > 1) begin
        s = s * 2; ex = ex - 1; shifts++;
      end
      m = MW'(s);
      if (s < hid) begin
        un = 1; eo = '0; lat = 3 + shifts;
      end else begin
        eo = EW'(ex); lat = 2 + shifts;
      end
    end
  endtask

  // Launch one operation; optionally pester with start while busy, then check against the model.
  task automatic run_op(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic sub,
                        input logic [EW-1:0] e, input bit busy_start);
    logic [MW-1:0] em;
    logic [EW-1:0] ee;
    logic efl, ez, eov, eun;
    int elat, got_lat;
    model(a, b, sub, e, em, ee, efl, ez, eov, eun, elat);
    @(negedge clk);
    check("ready_idle", ready, 1'b1);
    saved_mants = {a, b};
    op_sub = sub;
    exp_in = e;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    got_lat = -1;
    for (int n = 2; n <= 64; n++) begin
      if (busy_start && n == 2) begin
        saved_mants = {MW'(25'h1FFFFFF), MW'(25'h1FFFFFF)};
        op_sub = 1'b0;
        exp_in = 8'd3;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      if (busy_start && n == 2) start = 1'b0;
      if (done) begin
        got_lat = n;
        break;
      end
    end
    check("latency", 64'(got_lat), 64'(elat));
    check("mant_out", mant_out, em);
    check("exp_out", exp_out, ee);
    check("flags", {sign_flip, zero, overflow, underflow}, {efl, ez, eov, eun});
    @(posedge clk);
    #1;
    check("done_pulse", {done, ready}, 2'b01);
    if (busy_start) begin
      for (int n = 0; n < 4; n++) begin
        @(posedge clk);
        #1;
        check("no_queued", {done, ready}, 2'b01);
      end
    end
  endtask

  initial begin
    logic [MW-1:0] ra, rb;
    logic [EW-1:0] re;
    bit abort_done;
    clear = 1'b1;
    start = 1'b0;
    saved_mants = '0;
    op_sub = 1'b0;
    exp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", ready, 1'b1);
    check("reset_outs", {mant_out, exp_out, sign_flip, zero, overflow, underflow, done}, '0);
    clear = 1'b0;

    run_op(25'h1000000, 25'h1000000, 1'b0, 8'd127, 1'b0);
    run_op(25'h1000000, 25'h0800000, 1'b1, 8'd127, 1'b0);
    run_op(25'h0800000, 25'h1000000, 1'b1, 8'd127, 1'b0);
    run_op(25'h1234567, 25'h1234567, 1'b1, 8'd127, 1'b0);
    run_op(25'h1000000, 25'h1000000, 1'b0, 8'd254, 1'b0);
    run_op(25'h1000000, 25'h0FFFFFF, 1'b1, 8'd1, 1'b0);
    run_op(25'h1000000, 25'h0FFFFFF, 1'b1, 8'd127, 1'b1);

    // Abort in the middle of a long left-normalization.
    @(negedge clk);
    saved_mants = {25'h1000000, 25'h0FFFFFF};
    op_sub = 1'b1;
    exp_in = 8'd127;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check("abort_ready", ready, 1'b1);
    check("abort_outs", {mant_out, exp_out, sign_flip, zero, overflow, underflow, done}, '0);
    abort_done = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (done) abort_done = 1;
    end
    check("abort_no_done", abort_done, 1'b0);

    for (int i = 0; i < 300; i++) begin
      ra = MW'($urandom) >> $urandom_range(0, 8);
      rb = MW'($urandom) >> $urandom_range(0, MW);
      if ($urandom_range(0, 3) == 0) ra = MW'(25'h1000000);
      if ($urandom_range(0, 7) == 0) rb = ra;
      case ($urandom_range(0, 5))
        0: re = 8'd0;
        1: re = 8'd1;
        2: re = 8'd254;
        3: re = EW'($urandom_range(2, 6));
        default: re = EW'($urandom_range(0, 254));
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), re, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
